// File: rtl/uart_pkg.sv
// Shared UART definitions: oversampling geometry, sample points and the
// receiver/transmitter state encoding.
package uart_pkg;

  // Line oversampling factor and payload size.
  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS  = 8;

  // Tick indices (within a bit) used for the three-point majority vote.
  localparam int SAMPLE_TICK_0 = 7;
  localparam int SAMPLE_TICK_1 = 8;
  localparam int SAMPLE_TICK_2 = 9;

  // State encoding kept as plain constants so older tools and the
  // transmitter can share it unchanged.
  typedef logic [2:0] uart_state_t;

  localparam uart_state_t ST_IDLE   = 3'd0;
  localparam uart_state_t ST_START  = 3'd1;
  localparam uart_state_t ST_DATA   = 3'd2;
  localparam uart_state_t ST_PARITY = 3'd3;
  localparam uart_state_t ST_STOP   = 3'd4;

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: one-cycle tick every OVERSAMPLE_DIV clocks.
// A restart pulse realigns the divider so that the first tick follows the
// restart on the very next cycle, phase-locking the tick grid to the start
// edge of a frame.
module uart_baud_tick #(
  parameter int OVERSAMPLE_DIV = 27
) (
  input  logic clock,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int CNT_W = (OVERSAMPLE_DIV > 2) ? $clog2(OVERSAMPLE_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE_DIV - 1);

  logic [CNT_W-1:0] div_cnt;

  // Free-running modulo-OVERSAMPLE_DIV counter, cleared on restart.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (restart || (div_cnt == CNT_LAST)) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Tick is high for the single cycle in which the counter sits at zero.
  assign tick = (div_cnt == '0);

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: 8 data bits, optional parity, one stop bit, 16x
// oversampling with a 3-point majority vote per bit. Received bytes are
// offered on a valid/ready handshake together with framing and parity
// flags; a frame that completes while the previous byte is still pending
// is dropped and reported with a one-cycle overrun pulse.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE_DIV = 27,
  parameter bit PARITY_EN      = 1'b0,
  parameter bit PARITY_ODD     = 1'b0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 Rx,
  input  logic                 Rx_ready,
  output logic [DATA_BITS-1:0] Rx_data,
  output logic                 Rx_valid,
  output logic                 frame_error,
  output logic                 parity_error,
  output logic                 overrun,
  output logic                 Rx_Busy
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_BITS);

  localparam logic [TICK_W-1:0] TICK_S0  = TICK_W'(SAMPLE_TICK_0);
  localparam logic [TICK_W-1:0] TICK_S1  = TICK_W'(SAMPLE_TICK_1);
  localparam logic [TICK_W-1:0] TICK_S2  = TICK_W'(SAMPLE_TICK_2);
  localparam logic [TICK_W-1:0] TICK_END = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(DATA_BITS - 1);

  // Two-out-of-three vote over the samples taken at ticks 7, 8 and 9.
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Parity bit the transmitter should have sent for this payload.
  function automatic logic expected_parity(input logic [DATA_BITS-1:0] d);
    return (^d) ^ PARITY_ODD;
  endfunction

  // Line synchronizer and edge detector.
  logic rx_sync_p0;
  logic rx_sync_p1;
  logic rx_prev;

  // Frame control state.
  uart_state_t       state;
  uart_state_t       state_nx;
  logic [TICK_W-1:0] tick_cnt;
  logic [TICK_W-1:0] tick_cnt_nx;
  logic [BIT_W-1:0]  bit_cnt;
  logic [BIT_W-1:0]  bit_cnt_nx;
  logic              par_err_q;
  logic              par_err_nx;

  // Bit recovery datapath.
  logic                 samp_a;
  logic                 samp_b;
  logic [DATA_BITS-1:0] shift_q;

  // Decoded events.
  logic tick;
  logic restart;
  logic fall_edge;
  logic at_decide;
  logic at_end;
  logic bit_val;
  logic frame_done;

  uart_baud_tick #(
    .OVERSAMPLE_DIV(OVERSAMPLE_DIV)
  ) u_baud_tick (
    .clock  (clock),
    .reset  (reset),
    .restart(restart),
    .tick   (tick)
  );

  // Bring the asynchronous line into the clock domain; idle level is 1 so
  // reset never fabricates a start edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_sync_p0 <= 1'b1;
      rx_sync_p1 <= 1'b1;
      rx_prev    <= 1'b1;
    end else begin
      rx_sync_p0 <= Rx;
      rx_sync_p1 <= rx_sync_p0;
      rx_prev    <= rx_sync_p1;
    end
  end

  assign fall_edge  = rx_prev & ~rx_sync_p1;
  assign at_decide  = tick & (tick_cnt == TICK_S2);
  assign at_end     = tick & (tick_cnt == TICK_END);
  assign bit_val    = majority3(samp_a, samp_b, rx_sync_p1);
  assign restart    = (state == ST_IDLE) & fall_edge;
  assign frame_done = (state == ST_STOP) & at_decide;

  // Frame sequencing: the tick counter walks 0..15 inside each bit and the
  // state advances on the last tick, except STOP which finishes at the
  // decision tick so a back-to-back start bit is never missed.
  always_comb begin
    state_nx    = state;
    tick_cnt_nx = tick_cnt;
    bit_cnt_nx  = bit_cnt;
    par_err_nx  = par_err_q;

    if ((state != ST_IDLE) && tick) begin
      tick_cnt_nx = tick_cnt + 1'b1;
    end

    case (state)
      ST_IDLE: begin
        if (fall_edge) begin
          state_nx    = ST_START;
          tick_cnt_nx = '0;
          bit_cnt_nx  = '0;
          par_err_nx  = 1'b0;
        end
      end
      ST_START: begin
        // A start bit that votes high was only a glitch.
        if (at_decide && bit_val) begin
          state_nx = ST_IDLE;
        end else if (at_end) begin
          state_nx = ST_DATA;
        end
      end
      ST_DATA: begin
        if (at_end) begin
          bit_cnt_nx = bit_cnt + 1'b1;
          if (bit_cnt == BIT_LAST) begin
            state_nx = PARITY_EN ? ST_PARITY : ST_STOP;
          end
        end
      end
      ST_PARITY: begin
        if (at_decide) begin
          par_err_nx = bit_val ^ expected_parity(shift_q);
        end
        if (at_end) begin
          state_nx = ST_STOP;
        end
      end
      ST_STOP: begin
        if (at_decide) begin
          state_nx = ST_IDLE;
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // Control registers; an asserted reset abandons any partial frame.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      par_err_q <= 1'b0;
    end else begin
      state     <= state_nx;
      tick_cnt  <= tick_cnt_nx;
      bit_cnt   <= bit_cnt_nx;
      par_err_q <= par_err_nx;
    end
  end

  // Capture the vote samples and shift data bits in LSB first; every frame
  // overwrites the whole shifter, so no reset is needed here.
  always_ff @(posedge clock) begin
    if (tick && (tick_cnt == TICK_S0)) begin
      samp_a <= rx_sync_p1;
    end
    if (tick && (tick_cnt == TICK_S1)) begin
      samp_b <= rx_sync_p1;
    end
    if ((state == ST_DATA) && at_decide) begin
      shift_q <= {bit_val, shift_q[DATA_BITS-1:1]};
    end
  end

  // Output handshake: load on completion when the slot is free (or being
  // freed this cycle), otherwise drop the frame and flag the overrun.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      Rx_data      <= '0;
      Rx_valid     <= 1'b0;
      frame_error  <= 1'b0;
      parity_error <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      overrun <= frame_done & Rx_valid & ~Rx_ready;
      if (frame_done && (!Rx_valid || Rx_ready)) begin
        Rx_data      <= shift_q;
        Rx_valid     <= 1'b1;
        frame_error  <= ~bit_val;
        parity_error <= PARITY_EN & par_err_q;
      end else if (Rx_valid && Rx_ready) begin
        Rx_valid <= 1'b0;
      end
    end
  end

  assign Rx_Busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: one receiver without parity, one with even
// parity, driven by a behavioural serial transmitter. Expected bytes and
// flags come from a frame-level model of what was put on the line.
`timescale 1ns/1ps
module tb_uart_rx_core;

  localparam int DIV      = 4;
  localparam int BIT_CLKS = 16 * DIV;
  localparam bit PAR_ODD  = 1'b0;

  typedef struct packed {
    logic [7:0] data;
    logic       fe;
    logic       pe;
  } rx_rec_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic rx_a  = 1'b1;
  logic rdy_a = 1'b1;
  logic rx_b  = 1'b1;
  logic rdy_b = 1'b1;

  logic [7:0] a_data, b_data;
  logic a_valid, a_fe, a_pe, a_ovr, a_busy;
  logic b_valid, b_fe, b_pe, b_ovr, b_busy;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  uart_rx_core #(.OVERSAMPLE_DIV(DIV), .PARITY_EN(1'b0), .PARITY_ODD(PAR_ODD)) dut_a (
    .clock(clock), .reset(reset), .Rx(rx_a), .Rx_ready(rdy_a),
    .Rx_data(a_data), .Rx_valid(a_valid), .frame_error(a_fe),
    .parity_error(a_pe), .overrun(a_ovr), .Rx_Busy(a_busy));

  uart_rx_core #(.OVERSAMPLE_DIV(DIV), .PARITY_EN(1'b1), .PARITY_ODD(PAR_ODD)) dut_b (
    .clock(clock), .reset(reset), .Rx(rx_b), .Rx_ready(rdy_b),
    .Rx_data(b_data), .Rx_valid(b_valid), .frame_error(b_fe),
    .parity_error(b_pe), .overrun(b_ovr), .Rx_Busy(b_busy));

  // Cycle counter and output monitors (sampled on the falling edge).
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  rx_rec_t acc_a[$];
  rx_rec_t acc_b[$];
  int rise_a = 0, rise_b = 0;
  int vld_len_a = 0, last_len_a = 0;
  int ovr_a = 0, ovr_b = 0, ovr_wide_a = 0;
  logic vld_d_a = 1'b0, vld_d_b = 1'b0, ovr_d_a = 1'b0;
  int tx_start_cyc = 0;

  always @(negedge clock) begin
    if (a_valid && rdy_a) acc_a.push_back({a_data, a_fe, a_pe});
    if (b_valid && rdy_b) acc_b.push_back({b_data, b_fe, b_pe});
    if (a_valid && !vld_d_a) rise_a <= cyc;
    if (b_valid && !vld_d_b) rise_b <= cyc;
    if (a_valid) vld_len_a <= vld_len_a + 1;
    else if (vld_d_a) begin
      last_len_a <= vld_len_a;
      vld_len_a  <= 0;
    end
    vld_d_a <= a_valid;
    vld_d_b <= b_valid;
    if (a_ovr) begin
      ovr_a <= ovr_a + 1;
      if (ovr_d_a) ovr_wide_a <= ovr_wide_a + 1;
    end
    if (b_ovr) ovr_b <= ovr_b + 1;
    ovr_d_a <= a_ovr;
  end

  // Frame-level reference: what the receiver must report for a frame.
  function automatic rx_rec_t model_frame(input logic [7:0] d, input bit with_par,
                                          input logic par_bit, input logic stop_bit);
    rx_rec_t r;
    r.data = d;
    r.fe   = (stop_bit == 1'b0);
    r.pe   = with_par && (par_bit != ((^d) ^ PAR_ODD));
    return r;
  endfunction

  function automatic int model_latency(input bit with_par);
    return 2 + 1 + (16 * (9 + int'(with_par)) + 9) * DIV + 1;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic drive_line(input bit sel_b, input logic v);
    if (sel_b) rx_b = v;
    else rx_a = v;
  endtask

  task automatic send_frame(input bit sel_b, input logic [7:0] d, input bit with_par,
                            input logic par_bit, input logic stop_bit, input int period);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (with_par) bits.push_back(par_bit);
    bits.push_back(stop_bit);
    tx_start_cyc = cyc;
    foreach (bits[i]) begin
      drive_line(sel_b, bits[i]);
      idle(period);
    end
  endtask

  task automatic test_reset();
    idle(3);
    n_cmp++;
    if (a_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", a_valid); end
    n_cmp++;
    if (a_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", a_data); end
    n_cmp++;
    if ({a_fe, a_pe, a_ovr} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got %b want 000", {a_fe, a_pe, a_ovr});
    end
    n_cmp++;
    if ({a_busy, b_busy, b_valid} !== 3'b000) begin
      n_fail++; $display("FAIL reset_busy: got %b want 000", {a_busy, b_busy, b_valid});
    end
    reset = 1'b0;
    idle(4);
  endtask

  task automatic test_loopback();
    rx_rec_t exp;
    int lat;
    rdy_a = 1'b1;
    acc_a.delete();
    send_frame(1'b0, 8'hAA, 1'b0, 1'b0, 1'b1, BIT_CLKS);
    lat = rise_a - tx_start_cyc;
    idle(BIT_CLKS);
    exp = model_frame(8'hAA, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (acc_a.size() != 1) begin
      n_fail++; $display("FAIL loop_count: got %0d want 1", acc_a.size());
    end else begin
      n_cmp++;
      if (acc_a[0] !== exp) begin n_fail++; $display("FAIL loop_rec: got %h want %h", acc_a[0], exp); end
    end
    n_cmp++;
    if (lat != model_latency(1'b0)) begin
      n_fail++; $display("FAIL loop_latency: got %0d want %0d", lat, model_latency(1'b0));
    end
    n_cmp++;
    if (last_len_a != 1) begin n_fail++; $display("FAIL loop_valid_len: got %0d want 1", last_len_a); end
  endtask

  task automatic test_glitch();
    acc_a.delete();
    rx_a = 1'b0;
    idle(3 * DIV);
    n_cmp++;
    if (a_busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_during: got %b want 1", a_busy); end
    idle(DIV);
    rx_a = 1'b1;
    idle(32 * DIV);
    n_cmp++;
    if ({a_busy, a_valid} !== 2'b00) begin
      n_fail++; $display("FAIL glitch_idle: got %b want 00", {a_busy, a_valid});
    end
    n_cmp++;
    if (acc_a.size() != 0) begin n_fail++; $display("FAIL glitch_count: got %0d want 0", acc_a.size()); end
  endtask

  task automatic test_frame_error();
    rx_rec_t exp;
    rdy_a = 1'b1;
    acc_a.delete();
    send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b0, BIT_CLKS);
    rx_a = 1'b1;
    idle(BIT_CLKS);
    exp = model_frame(8'h55, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (acc_a.size() != 1 || acc_a[0] !== exp) begin
      n_fail++; $display("FAIL frame_err: got n=%0d rec=%h want %h", acc_a.size(),
                         (acc_a.size() > 0) ? acc_a[0] : 10'h0, exp);
    end
    // Break: line held low for longer than a frame yields one 0x00 frame.
    acc_a.delete();
    rx_a = 1'b0;
    idle(12 * BIT_CLKS);
    rx_a = 1'b1;
    idle(2 * BIT_CLKS);
    exp = model_frame(8'h00, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (acc_a.size() != 1 || acc_a[0] !== exp) begin
      n_fail++; $display("FAIL break: got n=%0d rec=%h want %h", acc_a.size(),
                         (acc_a.size() > 0) ? acc_a[0] : 10'h0, exp);
    end
  endtask

  task automatic test_parity();
    rx_rec_t exp1, exp0;
    int lat;
    rdy_b = 1'b1;
    acc_b.delete();
    send_frame(1'b1, 8'h03, 1'b1, 1'b1, 1'b1, BIT_CLKS);
    lat = rise_b - tx_start_cyc;
    idle(4);
    send_frame(1'b1, 8'h03, 1'b1, 1'b0, 1'b1, BIT_CLKS);
    idle(BIT_CLKS);
    exp1 = model_frame(8'h03, 1'b1, 1'b1, 1'b1);
    exp0 = model_frame(8'h03, 1'b1, 1'b0, 1'b1);
    n_cmp++;
    if (lat != model_latency(1'b1)) begin
      n_fail++; $display("FAIL par_latency: got %0d want %0d", lat, model_latency(1'b1));
    end
    n_cmp++;
    if (acc_b.size() != 2) begin
      n_fail++; $display("FAIL par_count: got %0d want 2", acc_b.size());
    end else begin
      n_cmp++;
      if (acc_b[0] !== exp1) begin n_fail++; $display("FAIL par_bad: got %h want %h", acc_b[0], exp1); end
      n_cmp++;
      if (acc_b[1] !== exp0) begin n_fail++; $display("FAIL par_good: got %h want %h", acc_b[1], exp0); end
    end
  endtask

  task automatic test_overrun();
    int ovr0;
    rdy_a = 1'b0;
    acc_a.delete();
    ovr0 = ovr_a;
    send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1, BIT_CLKS);
    send_frame(1'b0, 8'h22, 1'b0, 1'b0, 1'b1, BIT_CLKS);
    idle(BIT_CLKS);
    n_cmp++;
    if (ovr_a - ovr0 != 1) begin n_fail++; $display("FAIL ovr_count: got %0d want 1", ovr_a - ovr0); end
    n_cmp++;
    if (ovr_wide_a != 0) begin n_fail++; $display("FAIL ovr_width: got %0d want 0", ovr_wide_a); end
    n_cmp++;
    if ({a_valid, a_data} !== {1'b1, 8'h11}) begin
      n_fail++; $display("FAIL ovr_hold: got %b/%h want 1/11", a_valid, a_data);
    end
    n_cmp++;
    if (acc_a.size() != 0) begin n_fail++; $display("FAIL ovr_early_accept: got %0d want 0", acc_a.size()); end
    rdy_a = 1'b1;
    idle(2);
    n_cmp++;
    if (a_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_release: got %b want 0", a_valid); end
    n_cmp++;
    if (acc_a.size() != 1 || acc_a[0].data !== 8'h11) begin
      n_fail++; $display("FAIL ovr_accept: got n=%0d data=%h want 11", acc_a.size(),
                         (acc_a.size() > 0) ? acc_a[0].data : 8'h00);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] partial;
    rx_rec_t exp;
    partial = 8'h96;
    rdy_a = 1'b0;
    send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1, BIT_CLKS);
    idle(4);
    rx_a = 1'b0;
    idle(BIT_CLKS);
    for (int i = 0; i < 3; i++) begin
      rx_a = partial[i];
      idle(BIT_CLKS);
    end
    rx_a = partial[3];
    idle(BIT_CLKS / 2);
    n_cmp++;
    if ({a_busy, a_valid} !== 2'b11) begin
      n_fail++; $display("FAIL midrst_pre: got %b want 11", {a_busy, a_valid});
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({a_valid, a_data, a_fe, a_pe, a_ovr, a_busy} !== 13'h0) begin
      n_fail++; $display("FAIL midrst_outputs: got %h want 0", {a_valid, a_data, a_fe, a_pe, a_ovr, a_busy});
    end
    rx_a = 1'b1;
    idle(BIT_CLKS);
    reset = 1'b0;
    idle(BIT_CLKS);
    rdy_a = 1'b1;
    acc_a.delete();
    send_frame(1'b0, 8'hC3, 1'b0, 1'b0, 1'b1, BIT_CLKS);
    idle(BIT_CLKS);
    exp = model_frame(8'hC3, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (acc_a.size() != 1 || acc_a[0] !== exp) begin
      n_fail++; $display("FAIL midrst_next: got n=%0d rec=%h want %h", acc_a.size(),
                         (acc_a.size() > 0) ? acc_a[0] : 10'h0, exp);
    end
  endtask

  task automatic test_random();
    rx_rec_t exp_a[$];
    rx_rec_t exp_b[$];
    int ovr_a0, ovr_b0;
    rdy_a = 1'b1;
    rdy_b = 1'b1;
    acc_a.delete();
    acc_b.delete();
    ovr_a0 = ovr_a;
    ovr_b0 = ovr_b;
    for (int n = 0; n < 24; n++) begin
      bit         sel;
      logic [7:0] d;
      int         per;
      logic       pb;
      logic       sb;
      sel = 1'($urandom_range(0, 1));
      d   = 8'($urandom_range(0, 255));
      per = BIT_CLKS - 1 + int'($urandom_range(0, 2));
      pb  = 1'($urandom_range(0, 1));
      sb  = ($urandom_range(0, 7) != 0);
      send_frame(sel, d, sel, pb, sb, per);
      if (sel) exp_b.push_back(model_frame(d, 1'b1, pb, sb));
      else exp_a.push_back(model_frame(d, 1'b0, pb, sb));
      if (!sb) begin
        drive_line(sel, 1'b1);
        idle(2 + int'($urandom_range(0, 3)));
      end else begin
        idle(int'($urandom_range(0, 3)));
      end
    end
    idle(2 * BIT_CLKS);
    n_cmp++;
    if (acc_a.size() != exp_a.size()) begin
      n_fail++; $display("FAIL rand_count_a: got %0d want %0d", acc_a.size(), exp_a.size());
    end
    n_cmp++;
    if (acc_b.size() != exp_b.size()) begin
      n_fail++; $display("FAIL rand_count_b: got %0d want %0d", acc_b.size(), exp_b.size());
    end
    for (int i = 0; i < exp_a.size() && i < acc_a.size(); i++) begin
      n_cmp++;
      if (acc_a[i] !== exp_a[i]) begin
        n_fail++; $display("FAIL rand_a[%0d]: got %h want %h", i, acc_a[i], exp_a[i]);
      end
    end
    for (int i = 0; i < exp_b.size() && i < acc_b.size(); i++) begin
      n_cmp++;
      if (acc_b[i] !== exp_b[i]) begin
        n_fail++; $display("FAIL rand_b[%0d]: got %h want %h", i, acc_b[i], exp_b[i]);
      end
    end
    n_cmp++;
    if ((ovr_a - ovr_a0) + (ovr_b - ovr_b0) != 0) begin
      n_fail++; $display("FAIL rand_overrun: got %0d want 0", (ovr_a - ovr_a0) + (ovr_b - ovr_b0));
    end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_glitch();
    test_frame_error();
    test_parity();
    test_overrun();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Time limit so a stuck run still ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1);
  end

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Standalone UART receiver: the far end of the serial link driven by the team's `Uart` transmitter (`Tx` → `Rx`). It recovers 8N1 (optionally 8E1/8O1) frames using 16x oversampling with majority-vote sampling, and delivers each byte through a valid/ready handshake. Framing, parity and overrun errors are flagged alongside the data. It sits between the pad-level `Rx` line and the byte consumer (FIFO or command parser).

## Interface
- `OVERSAMPLE_DIV`, 27: clocks per 1/16-bit tick (50 MHz / 115200 / 16); legal range ≥ 2.
- `PARITY_EN`, 0: 1 = a parity bit follows the data bits.
- `PARITY_ODD`, 0: 1 = odd parity, 0 = even; ignored when `PARITY_EN` = 0.
- `clock`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `Rx`  in  1  serial line, idle high, asynchronous to `clock`.
- `Rx_ready`  in  1  consumer accepts `Rx_data` when `Rx_valid` & `Rx_ready`.
- `Rx_data`  out  8  received byte, LSB first on the line.
- `Rx_valid`  out  1  `Rx_data` and error flags are valid; held until accepted.
- `frame_error`  out  1  stop bit sampled low; qualified by `Rx_valid`.
- `parity_error`  out  1  parity mismatch; qualified by `Rx_valid`; always 0 when `PARITY_EN` = 0.
- `overrun`  out  1  one-cycle pulse: a frame completed while `Rx_valid` was still high.
- `Rx_Busy`  out  1  high in every state except IDLE.

## Operation
- `Rx` passes through a 2-flop synchronizer (reset value 1); all logic uses the synchronized value.
- States: IDLE → START → DATA → PARITY (only if `PARITY_EN`) → STOP → IDLE.
- IDLE: falling edge (synced 1 → 0) enters START, clears the tick divider and the tick count.
- Tick count 0..15 per bit; sample = majority of the synced line at ticks 7, 8, 9, decided at tick 9.
- START: majority 1 at tick 9 → false start, return to IDLE, nothing reported. Majority 0 → continue; at tick 15 go to DATA.
- DATA: 8 bits, shifted LSB first; after bit 7 tick 15 go to PARITY or STOP.
- PARITY: expected bit = XOR of data, inverted if `PARITY_ODD`; a mismatch sets the parity flag.
- STOP: at tick 9 sample the stop bit; 0 sets the frame flag. Return to IDLE on that same tick; do not wait for the end of the stop bit, so back-to-back frames are accepted.
- Completion, with `Rx_valid` = 0 or accepted in the same cycle: load `Rx_data`, the error flags and `Rx_valid` = 1.
- Completion with `Rx_valid` = 1 and not accepted: pulse `overrun`; the new byte and its flags are dropped; old data is held.
- Break (line held low): frame completes with `Rx_data` = 0x00 and `frame_error` = 1. IDLE detects a new start only after the line returns high, because detection is edge-based.
- Reset, including mid-frame: state IDLE, all outputs 0, synchronizer 1, divider and counters 0. A partial frame is discarded.

## Timing
- One tick every `OVERSAMPLE_DIV` clocks; the divider restarts on start detection.
- Latency: falling edge on `Rx` to `Rx_valid` high = 2 (synchronizer) + 1 (edge) + (16·(9 + `PARITY_EN`) + 9)·`OVERSAMPLE_DIV` + 1 clocks.
- `Rx_valid` drops the cycle after `Rx_valid` & `Rx_ready`.
- `overrun` is high for exactly one clock.
- Tolerates a baud mismatch of ±3 % over a frame.

## Structure
- Package `uart_pkg`: state enum, `OVERSAMPLE` = 16, sample ticks 7/8/9, `DATA_BITS` = 8. Shared with the transmitter.
- Sub-module `uart_baud_tick`: parameterised divider with a synchronous restart input and a one-cycle `tick` output.

## Test plan
- Loopback from `Uart.Tx`, `Tx_data` = 0xAA, `Rx_ready` = 1 → `Rx_data` = 0xAA, one-cycle `Rx_valid`, no error flags, latency matches the formula.
- Low glitch of 4 ticks on idle `Rx` → no `Rx_valid`; `Rx_Busy` returns to 0; state IDLE.
- Frame 0x55 with stop bit driven 0 → `Rx_data` = 0x55, `frame_error` = 1.
- `PARITY_EN` = 1, even, byte 0x03 with parity bit 1 → `parity_error` = 1; with parity bit 0 → `parity_error` = 0.
- `Rx_ready` = 0, send 0x11 then 0x22 → `Rx_data` stays 0x11, `overrun` pulses once, then `Rx_ready` = 1 accepts 0x11.
- Assert `reset` during DATA bit 3 → all outputs 0 immediately; the next frame 0xC3 is received correctly.
